// File: rtl/bram_stream_reader_if.sv
// Purpose: valid/ready stream carrying RAM words with an end-of-transfer flag.
// Latency: none, wires only.
// Backpressure: master holds m_data/m_last stable while m_valid=1 and m_ready=0.
interface bram_stream_reader_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Purpose: walks a contiguous RAM address range on start and streams the words out with a last flag.
// Latency: start accepted at edge T, raddr=start_addr after T, first beat valid after T+2; 1 word/cycle.
// Backpressure: 2-entry output buffer; reads are issued only when buffer plus in-flight read has room.
module bram_stream_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              start,
    input  logic [AW-1:0]     start_addr,
    input  logic [AW:0]       length,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     raddr,
    input  logic [WIDTH-1:0]  rdata,
    bram_stream_reader_if.master strm
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    raddr_q, raddr_d;
    logic [AW:0]      issue_left_q, issue_left_d;
    logic [AW:0]      send_left_q, send_left_d;
    logic             inflight_q, inflight_d;
    logic             inflight_last_q, inflight_last_d;
    logic             done_q, done_d;
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] head_dat_q, head_dat_d;
    logic             head_last_q, head_last_d;
    logic [WIDTH-1:0] tail_dat_q, tail_dat_d;
    logic             tail_last_q, tail_last_d;

    logic             pop;
    logic             push;
    logic [1:0]       level;
    logic             issue_ok;
    logic [AW-1:0]    raddr_nxt;

    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    // A RAM word arrives in the cycle after its address was presented with
    // the in-flight flag set; the buffer must have room for it by then, so
    // the issue decision counts the in-flight word as already occupying a slot.
    assign pop       = (occ_q != 2'd0) && strm.m_ready;
    assign push      = inflight_q;
    assign level     = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    assign issue_ok  = (state_q == RUN) && (issue_left_q != '0) && (level < 2'd2);
    assign raddr_nxt = (raddr_q == AW'(DEPTH - 1)) ? '0 : raddr_q + 1'b1;

    // Transfer control: start acceptance, read issue, completion and done pulse.
    always_comb begin
        state_d         = state_q;
        raddr_d         = raddr_q;
        issue_left_d    = issue_left_q;
        send_left_d     = send_left_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        done_d          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d      = RUN;
                        raddr_d      = start_addr;
                        issue_left_d = length;
                        send_left_d  = length;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue_ok) begin
                    inflight_d      = 1'b1;
                    inflight_last_d = (issue_left_q == ONE);
                    issue_left_d    = issue_left_q - ONE;
                    // Only step the address when another read follows, so
                    // raddr rests on the final address of the range.
                    if (issue_left_q > ONE) begin
                        raddr_d = raddr_nxt;
                    end
                end
                if (pop) begin
                    send_left_d = send_left_q - ONE;
                    if (send_left_q == ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry output buffer: head drives the stream, tail absorbs one stalled word.
    always_comb begin
        occ_d       = occ_q;
        head_dat_d  = head_dat_q;
        head_last_d = head_last_q;
        tail_dat_d  = tail_dat_q;
        tail_last_d = tail_last_q;

        case (occ_q)
            2'd0: begin
                if (push) begin
                    head_dat_d  = rdata;
                    head_last_d = inflight_last_q;
                    occ_d       = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_dat_d  = rdata;
                    head_last_d = inflight_last_q;
                end else if (push) begin
                    tail_dat_d  = rdata;
                    tail_last_d = inflight_last_q;
                    occ_d       = 2'd2;
                end else if (pop) begin
                    occ_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_dat_d  = tail_dat_q;
                    head_last_d = tail_last_q;
                    if (push) begin
                        tail_dat_d  = rdata;
                        tail_last_d = inflight_last_q;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
        endcase
    end

    // State registers; reset drops any read still in flight.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q         <= IDLE;
            raddr_q         <= '0;
            issue_left_q    <= '0;
            send_left_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            occ_q           <= 2'd0;
            head_dat_q      <= '0;
            head_last_q     <= 1'b0;
            tail_dat_q      <= '0;
            tail_last_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            raddr_q         <= raddr_d;
            issue_left_q    <= issue_left_d;
            send_left_q     <= send_left_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
            occ_q           <= occ_d;
            head_dat_q      <= head_dat_d;
            head_last_q     <= head_last_d;
            tail_dat_q      <= tail_dat_d;
            tail_last_q     <= tail_last_d;
        end
    end

    assign busy         = (state_q == RUN);
    assign done         = done_q;
    assign raddr        = raddr_q;
    assign strm.m_valid = (occ_q != 2'd0);
    assign strm.m_data  = head_dat_q;
    assign strm.m_last  = head_last_q && (occ_q != 2'd0);

endmodule
